// File: rtl/escalonador_operar_vetores.sv
// Round-robin scheduler that shares one vector-operator datapath (bitwise OR,
// logical OR, NOT of {a,b}) between two requesters, one operation in flight.
module escalonador_operar_vetores #(
  parameter int WIDTH = 3,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic [WIDTH-1:0]   req0_b,
  input  logic [1:0]         req0_op,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic [WIDTH-1:0]   req1_b,
  input  logic [1:0]         req1_op,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic               resp_id,
  output logic [2*WIDTH-1:0] resp_data,
  output logic               resp_err,
  output logic [CNT_W-1:0]   op_count,
  output logic [1:0]         debug_state
);

  // Handshakes: a transfer happens on the rising edge where valid and ready
  // are both high. Requesters hold operands while valid & !ready; the consumer
  // sees resp_* stable from resp_valid rising until resp_valid & resp_ready.

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [1:0] OP_OR_BIT = 2'b00;
  localparam logic [1:0] OP_OR_LOG = 2'b01;
  localparam logic [1:0] OP_NOT    = 2'b10;

  state_t             state;
  state_t             state_nx;
  logic               last_grant;
  logic               grant;
  logic               any_valid;
  logic               accept;
  logic               retire;
  logic [WIDTH-1:0]   cap_a;
  logic [WIDTH-1:0]   cap_b;
  logic [1:0]         cap_op;
  logic               cap_id;
  logic [2*WIDTH-1:0] exec_data;
  logic               exec_err;

  // Round-robin: on contention the requester that did not win last time wins.
  always_comb begin
    any_valid = req0_valid | req1_valid;
    if (req0_valid && req1_valid) grant = ~last_grant;
    else                          grant = req1_valid;
  end

  assign accept = (state == ST_IDLE) && any_valid;
  assign retire = (state == ST_RESP) && resp_ready;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // FSM next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (any_valid) state_nx = ST_EXEC;
      ST_EXEC: state_nx = ST_RESP;
      ST_RESP: if (resp_ready) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    req0_ready  = (state == ST_IDLE) && req0_valid && !grant;
    req1_ready  = (state == ST_IDLE) && req1_valid && grant;
    resp_valid  = (state == ST_RESP);
    debug_state = state;
  end

  // Operator datapath, evaluated on the captured operands
  always_comb begin
    exec_data = '0;
    exec_err  = 1'b0;
    case (cap_op)
      OP_OR_BIT: exec_data = {{WIDTH{1'b0}}, cap_a | cap_b};
      OP_OR_LOG: exec_data = {{(2*WIDTH-1){1'b0}}, (|cap_a) || (|cap_b)};
      OP_NOT:    exec_data = ~{cap_a, cap_b};
      default:   exec_err  = 1'b1;
    endcase
  end

  // Operand capture, arbitration memory, result and counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      cap_a      <= '0;
      cap_b      <= '0;
      cap_op     <= '0;
      cap_id     <= 1'b0;
      resp_id    <= 1'b0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
      op_count   <= '0;
    end else begin
      if (accept) begin
        last_grant <= grant;
        cap_id     <= grant;
        cap_a      <= grant ? req1_a  : req0_a;
        cap_b      <= grant ? req1_b  : req0_b;
        cap_op     <= grant ? req1_op : req0_op;
      end
      if (state == ST_EXEC) begin
        resp_id   <= cap_id;
        resp_data <= exec_data;
        resp_err  <= exec_err;
      end
      if (retire) op_count <= op_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_escalonador_operar_vetores.sv
// Scoreboard bench for escalonador_operar_vetores: drivers issue operations,
// a negedge monitor checks arbitration, latency, hold-stability and results.
module tb_escalonador_operar_vetores;

  localparam int WIDTH = 3;
  localparam int CNT_W = 8;

  logic               clk;
  logic               rst_n;
  logic               req0_valid, req0_ready;
  logic [WIDTH-1:0]   req0_a, req0_b;
  logic [1:0]         req0_op;
  logic               req1_valid, req1_ready;
  logic [WIDTH-1:0]   req1_a, req1_b;
  logic [1:0]         req1_op;
  logic               resp_valid, resp_ready, resp_id, resp_err;
  logic [2*WIDTH-1:0] resp_data;
  logic [CNT_W-1:0]   op_count;
  logic [1:0]         debug_state;

  escalonador_operar_vetores #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
    .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
    .req1_b(req1_b), .req1_op(req1_op),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_data(resp_data), .resp_err(resp_err), .op_count(op_count),
    .debug_state(debug_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Returns {id, err, data}: result from the operator rules in plain arithmetic.
  function automatic logic [7:0] model(input logic id, input int a, input int b, input int op);
    int data;
    logic err;
    err = 1'b0;
    case (op)
      0: data = a | b;
      1: data = (a != 0 || b != 0) ? 1 : 0;
      2: data = 63 - (a * 8 + b);
      default: begin data = 0; err = 1'b1; end
    endcase
    return {id, err, data[5:0]};
  endfunction

  logic [7:0] exp_q[$];
  logic [7:0] mcount;
  logic       mlast;
  logic       busy;
  int         lat;
  logic       held;
  logic [7:0] held_val;
  logic       last_id, last_err;
  logic [5:0] last_data;
  logic       id_log[$];

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      mcount = '0;
      mlast  = 1'b1;
      busy   = 1'b0;
      held   = 1'b0;
      lat    = 0;
    end else begin
      check("op_count", op_count, mcount);
      if (!busy) begin
        logic w, any;
        any = req0_valid | req1_valid;
        w   = (req0_valid && req1_valid) ? !mlast : req1_valid;
        check("resp_valid_idle", resp_valid, 1'b0);
        check("req0_ready", req0_ready, any && !w);
        check("req1_ready", req1_ready, any && w);
        if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
          if (req1_valid && req1_ready)
            exp_q.push_back(model(1'b1, int'(req1_a), int'(req1_b), int'(req1_op)));
          else
            exp_q.push_back(model(1'b0, int'(req0_a), int'(req0_b), int'(req0_op)));
          mlast = req1_valid && req1_ready;
          busy  = 1'b1;
          lat   = 0;
        end
      end else begin
        lat++;
        check("readies_busy", {req0_ready, req1_ready}, 2'b00);
        check("latency", resp_valid, lat >= 2);
        if (resp_valid) begin
          if (held) check("hold_stable", {resp_id, resp_err, resp_data}, held_val);
          if (resp_ready) begin
            if (exp_q.size() == 0) begin
              check("unexpected_resp", 1, 0);
            end else begin
              check("resp", {resp_id, resp_err, resp_data}, exp_q.pop_front());
            end
            last_id   = resp_id;
            last_err  = resp_err;
            last_data = resp_data;
            id_log.push_back(resp_id);
            mcount = mcount + 8'd1;
            busy   = 1'b0;
            held   = 1'b0;
          end else begin
            held     = 1'b1;
            held_val = {resp_id, resp_err, resp_data};
          end
        end
      end
    end
  end

  // ---------------- drivers ----------------
  logic rr_random;
  initial begin
    rr_random  = 1'b0;
    resp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rr_random) resp_ready = ($urandom_range(0, 2) != 0);
    end
  end

  task automatic issue(input bit id, input int a, input int b, input int op);
    int n;
    logic rdy;
    if (id) begin
      req1_valid = 1'b1; req1_a = a[2:0]; req1_b = b[2:0]; req1_op = op[1:0];
    end else begin
      req0_valid = 1'b1; req0_a = a[2:0]; req0_b = b[2:0]; req0_op = op[1:0];
    end
    n = 0;
    do begin
      @(negedge clk);
      rdy = id ? req1_ready : req0_ready;
      n++;
    end while (!rdy && n < 300);
    if (!rdy) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    if (id) req1_valid = 1'b0;
    else    req0_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (busy && n < 300);
    if (busy) check("retire_timeout", 0, 1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_op = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_op = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_data", resp_data, 6'd0);
    check("rst_resp_id", resp_id, 1'b0);
    check("rst_resp_err", resp_err, 1'b0);
    check("rst_op_count", op_count, 8'd0);
    check("rst_state", debug_state, 2'd0);
    rst_n = 1'b1;

    // bitwise OR
    issue(0, 3'b011, 3'b010, 0); wait_idle();
    check("t1_data", last_data, 6'b000011);
    check("t1_id", last_id, 1'b0);
    // logical OR
    issue(1, 0, 0, 1); wait_idle();
    check("t2a_data", last_data, 6'b000000);
    issue(1, 0, 1, 1); wait_idle();
    check("t2b_data", last_data, 6'b000001);
    check("t2_id", last_id, 1'b1);
    // NOT and reserved op
    issue(0, 3'b101, 3'b011, 2); wait_idle();
    check("t3a_data", last_data, 6'b010100);
    check("t3a_err", last_err, 1'b0);
    issue(0, 3'b101, 3'b011, 3); wait_idle();
    check("t3b_data", last_data, 6'b000000);
    check("t3b_err", last_err, 1'b1);

    // contention right after reset alternates starting with requester 0
    do_reset();
    id_log.delete();
    fork
      begin for (int i = 0; i < 2; i++) issue(0, i, 2, 0); end
      begin for (int i = 0; i < 2; i++) issue(1, 4, i, 2); end
    join
    wait_idle();
    check("t4_count", id_log.size(), 4);
    for (int i = 0; i < 4 && i < id_log.size(); i++)
      check("t4_grant", id_log[i], i % 2);
    check("t4_op_count", op_count, 8'd4);

    // response back-pressure with another request pending
    resp_ready = 1'b0;
    issue(1, 5, 2, 0);
    fork
      issue(0, 7, 0, 1);
      begin repeat (6) @(posedge clk); #1 resp_ready = 1'b1; end
    join
    wait_idle();
    check("t5_last_id", last_id, 1'b0);

    // reset while an operation is executing
    issue(0, 1, 1, 0);
    check("t6_in_exec", debug_state, 2'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    check("t6_resp_valid", resp_valid, 1'b0);
    check("t6_op_count", op_count, 8'd0);
    check("t6_state", debug_state, 2'd0);
    repeat (4) @(posedge clk);
    #1 check("t6_no_resp", resp_valid, 1'b0);

    // counter wrap
    for (int i = 0; i < 255; i++) begin
      issue(i % 2, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3));
      wait_idle();
    end
    check("wrap_255", op_count, 8'd255);
    issue(1, 2, 2, 0); wait_idle();
    check("wrap_0", op_count, 8'd0);

    // random traffic on both requesters with random back-pressure
    rr_random = 1'b1;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          issue(0, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3));
        end
      end
      begin
        for (int i = 0; i < 60; i++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          issue(1, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3));
        end
      end
    join
    rr_random = 1'b0;
    resp_ready = 1'b1;
    wait_idle();
    check("queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
